// File: rtl/clk_div_pkg.sv
// Shared types, constants and clamp helpers for the clk_div_bank divider slice.
// Optional duty-cycle control is enabled by defining CLKDIV_DUTY_EN.
package clk_div_pkg;

  localparam int CLKDIV_CNT_W = 16;
  localparam int DIV_MIN      = 2;

  typedef logic [CLKDIV_CNT_W-1:0] div_t;

  // Divisors below two cannot produce a square wave, so they run as divide-by-two.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < 32'(DIV_MIN)) ? 32'(DIV_MIN) : div;
  endfunction

  function automatic logic [31:0] clamp_duty(input logic [31:0] duty, input logic [31:0] divEff);
    if (duty == 32'd0) begin
      return 32'd1;
    end else if (duty >= divEff) begin
      return divEff - 32'd1;
    end else begin
      return duty;
    end
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, pending flag and output flops.
// With CLKDIV_DUTY_EN defined the high time comes from a loaded duty value instead of D/2.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CLKDIV_CNT_W,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             sync_restart_i,
  input  logic             div_load_i,
  input  logic [CNT_W-1:0] div_val_i,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0] duty_val_i,
`endif
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             pending_o
);

  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(clamp_div(32'(DEF_DIV)));
  localparam logic [CNT_W-1:0] RST_HIGH = RST_DIV >> 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] shdDiv_q, shdDiv_d;
`ifdef CLKDIV_DUTY_EN
  logic [CNT_W-1:0] shdDuty_q, shdDuty_d;
  logic [CNT_W-1:0] srcDuty;
`endif
  logic             pending_q, pending_d;
  logic             clkOut_q, clkOut_d;
  logic             tick_q, tick_d;
  logic             wrap, restart, doApply;
  logic [CNT_W-1:0] srcDiv, newDiv, newHigh;

  // A load arriving on the apply cycle itself bypasses the shadow so it takes effect at that boundary.
  always_comb begin
    wrap    = (cnt_q == div_q - 1'b1);
    restart = sync_restart_i | ~en_i;
    srcDiv  = div_load_i ? div_val_i : shdDiv_q;
    newDiv  = CNT_W'(clamp_div(32'(srcDiv)));
`ifdef CLKDIV_DUTY_EN
    srcDuty   = div_load_i ? duty_val_i : shdDuty_q;
    newHigh   = CNT_W'(clamp_duty(32'(srcDuty), 32'(newDiv)));
    shdDuty_d = srcDuty;
`else
    newHigh = newDiv >> 1;
`endif
    doApply   = (pending_q | div_load_i) & (restart | wrap);
    shdDiv_d  = srcDiv;
    div_d     = doApply ? newDiv : div_q;
    high_d    = doApply ? newHigh : high_q;
    pending_d = (pending_q | div_load_i) & ~doApply;
    cnt_d     = (restart | wrap) ? '0 : cnt_q + 1'b1;
    clkOut_d  = en_i & (cnt_q < high_q);
    tick_d    = en_i & wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      div_q     <= RST_DIV;
      high_q    <= RST_HIGH;
      shdDiv_q  <= CNT_W'(DEF_DIV);
`ifdef CLKDIV_DUTY_EN
      shdDuty_q <= RST_HIGH;
`endif
      pending_q <= 1'b0;
      clkOut_q  <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      high_q    <= high_d;
      shdDiv_q  <= shdDiv_d;
`ifdef CLKDIV_DUTY_EN
      shdDuty_q <= shdDuty_d;
`endif
      pending_q <= pending_d;
      clkOut_q  <= clkOut_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out_o = clkOut_q;
  assign tick_o    = tick_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider producing in-domain divided waves and tick strobes.
// Define CLKDIV_DUTY_EN to add the per-channel duty_val_i high-time input.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = CLKDIV_CNT_W,
  parameter int DEF_DIV = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH*CNT_W-1:0] div_val_i,
  input  logic [NUM_CH-1:0]       div_load_i,
  input  logic                    sync_restart_i,
`ifdef CLKDIV_DUTY_EN
  input  logic [NUM_CH*CNT_W-1:0] duty_val_i,
`endif
  output logic [NUM_CH-1:0]       clk_out_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       pending_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_div_chan #(
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .en_i          (en_i[i]),
      .sync_restart_i(sync_restart_i),
      .div_load_i    (div_load_i[i]),
      .div_val_i     (div_val_i[i*CNT_W +: CNT_W]),
`ifdef CLKDIV_DUTY_EN
      .duty_val_i    (duty_val_i[i*CNT_W +: CNT_W]),
`endif
      .clk_out_o     (clk_out_o[i]),
      .tick_o        (tick_o[i]),
      .pending_o     (pending_o[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: stimulus queues expected outputs, a monitor pops and compares.
// Duty-cycle vectors are included when CLKDIV_DUTY_EN is defined.
module tb_clk_div_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  en;
  logic [63:0] divVal;
  logic [3:0]  divLoad;
  logic        syncRestart;
`ifdef CLKDIV_DUTY_EN
  logic [63:0] dutyVal;
`endif
  logic [3:0]  clkOut, tick, pending;

  typedef struct packed {
    logic [3:0] c;
    logic [3:0] t;
    logic [3:0] p;
    logic [7:0] ph;
  } exp_t;

  exp_t       expQ[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] phase = 8'd0;

  always #5 clk = ~clk;

  clk_div_bank dut (
    .clk           (clk),
    .reset         (reset),
    .en_i          (en),
    .div_val_i     (divVal),
    .div_load_i    (divLoad),
    .sync_restart_i(syncRestart),
`ifdef CLKDIV_DUTY_EN
    .duty_val_i    (dutyVal),
`endif
    .clk_out_o     (clkOut),
    .tick_o        (tick),
    .pending_o     (pending)
  );

  task automatic checkOutput(input logic [11:0] act, input logic [11:0] req, input logic [7:0] ph);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL phase%0d clk/tick/pend actual=%b_%b_%b required=%b_%b_%b",
               ph, act[11:8], act[7:4], act[3:0], req[11:8], req[7:4], req[3:0]);
    end
  endtask

  // Called at a negedge: drive inputs, queue the outputs expected after the next posedge.
  task automatic applyStimulus(input logic [3:0] enV, input logic [3:0] loadV, input logic syncV,
                               input logic [3:0] eC, input logic [3:0] eT, input logic [3:0] eP);
    exp_t e;
    en          = enV;
    divLoad     = loadV;
    syncRestart = syncV;
    e.c  = eC;
    e.t  = eT;
    e.p  = eP;
    e.ph = phase;
    expQ.push_back(e);
    @(negedge clk);
  endtask

  task automatic setDiv(input int ch, input logic [15:0] val);
    divVal[ch*16 +: 16] = val;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({clkOut, tick, pending}, {e.c, e.t, e.p}, e.ph);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [3:0] c, t, l;
    reset       = 1'b1;
    en          = 4'b0000;
    divVal      = '0;
    divLoad     = 4'b0000;
    syncRestart = 1'b0;
`ifdef CLKDIV_DUTY_EN
    dutyVal     = '0;
`endif
    @(negedge clk);

    // Reset dominates enable
    phase = 8'd1;
    applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;

    // Channel 0 at reset divisor 2
    phase = 8'd2;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000);
      applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000);
    end

    // Channel 1: load 5 mid-period, applied at wrap, then 2-high/3-low
    phase = 8'd3;
    setDiv(1, 16'd5);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000);
    applyStimulus(4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0010);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000);
      applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000);
      applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
      applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
      applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000);
    end

    // Last load wins (7 then 3), then div 0 and div 1 behave as 2
    phase = 8'd4;
    setDiv(1, 16'd7);
    applyStimulus(4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0010);
    setDiv(1, 16'd3);
    applyStimulus(4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0010);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000);
    phase = 8'd5;
    setDiv(1, 16'd0);
    applyStimulus(4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0010);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000);
    setDiv(1, 16'd1);
    applyStimulus(4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0010);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000);

    // ch0 D=3, ch1 D=5 loaded while disabled, pending 4 on ch1 applied by sync_restart
    phase = 8'd6;
    setDiv(0, 16'd3);
    setDiv(1, 16'd5);
    applyStimulus(4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0011, 4'b0000, 1'b0, 4'b0011, 4'b0000, 4'b0000);
    applyStimulus(4'b0011, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    setDiv(1, 16'd4);
    applyStimulus(4'b0011, 4'b0010, 1'b0, 4'b0000, 4'b0001, 4'b0010);
    applyStimulus(4'b0011, 4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b0000);
    phase = 8'd7;
    for (int j = 0; j < 24; j++) begin
      c = {2'b00, (j % 4) < 2, (j % 3) == 0};
      t = {2'b00, (j % 4) == 3, (j % 3) == 2};
      applyStimulus(4'b0011, 4'b0000, 1'b0, c, t, 4'b0000);
    end

    // ch2: en dropped with a pending load applies it at once
    phase = 8'd8;
    setDiv(2, 16'd6);
    applyStimulus(4'b0000, 4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000);
    setDiv(2, 16'd4);
    applyStimulus(4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0000, 4'b0100);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0100);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100, 4'b0000);
    setDiv(2, 16'd9);
    applyStimulus(4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0000, 4'b0100);

    // Async reset mid-count clears outputs immediately and discards the pending 9
    phase = 8'd9;
    reset = 1'b1;
    #1;
    checkOutput({clkOut, tick, pending}, 12'h000, phase);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000);
      applyStimulus(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100, 4'b0000);
    end

    // ch3 maximum divisor: 32767 high, 32768 low, one tick per 65535 cycles
    phase = 8'd10;
    setDiv(3, 16'hFFFF);
    applyStimulus(4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    for (int j = 0; j < 65537; j++) begin
      c = (j < 32767 || j == 65535 || j == 65536) ? 4'b1000 : 4'b0000;
      t = (j == 65534) ? 4'b1000 : 4'b0000;
      applyStimulus(4'b1000, 4'b0000, 1'b0, c, t, 4'b0000);
    end

`ifdef CLKDIV_DUTY_EN
    // ch0 duty: D=10 H=3, then duty 0 -> 1, duty 12 -> 9, then D=5 H=2; all loaded on wrap cycles
    phase = 8'd11;
    setDiv(0, 16'd10);
    dutyVal[15:0] = 16'd3;
    applyStimulus(4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    for (int j = 0; j < 35; j++) begin
      l = 4'b0000;
      if (j == 9) begin
        dutyVal[15:0] = 16'd0;
        l = 4'b0001;
      end else if (j == 19) begin
        dutyVal[15:0] = 16'd12;
        l = 4'b0001;
      end else if (j == 29) begin
        setDiv(0, 16'd5);
        dutyVal[15:0] = 16'd2;
        l = 4'b0001;
      end
      if (j < 10)      c = {3'b000, j < 3};
      else if (j < 20) c = {3'b000, j == 10};
      else if (j < 30) c = {3'b000, j < 29};
      else             c = {3'b000, j < 32};
      t = {3'b000, (j == 9) || (j == 19) || (j == 29) || (j == 34)};
      applyStimulus(4'b0001, l, 1'b0, c, t, 4'b0000);
    end
`endif

    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 10 && expQ.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d queued required=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
